s4ga_feeder: RTL
================

S4GA_FEEDER -- requirements
Module: s4ga_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4: byte FIFO depth, power of two, 2..16.
REQ-002 SHALL have parameter FRAME_NIBBLES, default 16: nibbles per configuration frame, 2..256.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  8  configuration byte from host.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a byte.
REQ-008 SHALL have port si  output  4  serial configuration nibble into s4ga.
REQ-009 SHALL have port si_valid  output  1  si carries a real nibble this cycle.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse on last nibble of a frame.
REQ-011 SHALL have port underrun  output  1  sticky mid-frame starvation flag.

Function
REQ-012 SHALL accept a byte at a rising edge where in_valid and in_ready are both 1; no other condition writes the FIFO.
REQ-013 SHALL drive in_ready = 1 exactly when FIFO occupancy < DEPTH, registered/combinational from state only, never from in_valid.
REQ-014 SHALL keep FIFO pointers DEPTH-wrapping; when full, in_ready=0 even if a pop occurs that cycle (no same-cycle pass-through).
REQ-015 SHALL implement serializer FSM with states IDLE, LO, HI; all outputs registered.
REQ-016 IDLE: si=0, si_valid=0; if FIFO non-empty at edge, pop byte into shift register, go LO.
REQ-017 LO: si=byte[3:0], si_valid=1; next edge unconditionally go HI.
REQ-018 HI: si=byte[7:4], si_valid=1; at edge, if FIFO non-empty pop and go LO, else go IDLE.
REQ-019 Latency: byte accepted at edge k into empty FIFO with FSM in IDLE SHALL give low nibble during cycle after edge k+1, high nibble during cycle after edge k+2.
REQ-020 Sustained throughput SHALL be one nibble per clock with no gap while FIFO stays non-empty.
REQ-021 Nibble counter SHALL increment once per si_valid cycle, wrap from FRAME_NIBBLES-1 to 0.
REQ-022 frame_done SHALL be 1 exactly in the cycle presenting the nibble with counter value FRAME_NIBBLES-1.
REQ-023 Push and pop in same edge with FIFO neither full nor empty SHALL leave occupancy unchanged and data order preserved.

Reset
REQ-024 rst at an edge SHALL force: FSM IDLE, FIFO empty, counter 0, si=0, si_valid=0, frame_done=0, underrun=0, in_ready=1 after that edge.
REQ-025 rst asserted mid-frame or mid-byte SHALL discard FIFO contents and partial byte; no nibble of discarded data appears after reset.
REQ-026 rst SHALL take priority over a simultaneous in_valid handshake (byte dropped).

Configuration
REQ-027 Macro S4GA_FEEDER_UNDERRUN_EN defined: underrun SHALL set when FSM leaves HI to IDLE with counter != 0 after increment (frame incomplete), remain 1 until rst.
REQ-028 Macro S4GA_FEEDER_UNDERRUN_EN undefined: underrun port SHALL exist and be tied constant 0; no detection logic.

Verification
REQ-029 Reset, then push 0xA5 once -> si=0x5 (si_valid=1) cycle after edge k+1, si=0xA next cycle, then si_valid=0, si=0.
REQ-030 Push 8 bytes 0x10..0x17 back-to-back (FRAME_NIBBLES=16) -> 16 consecutive nibbles 0,1,1,1,...,7,1 no gap; frame_done only on 16th; underrun=0.
REQ-031 Hold in_valid=1 with FSM stalled by no pops impossible; instead push DEPTH+2 bytes in consecutive cycles from reset -> in_ready drops to 0 when occupancy hits 4, no byte lost or duplicated on si.
REQ-032 Push 3 bytes then stop (FRAME_NIBBLES=16) -> after 6 nibbles FSM IDLE; underrun=1 with macro, 0 without.
REQ-033 Assert rst during 2nd nibble of byte 0x3C with 0x77 queued -> si_valid=0 after reset edge; neither 0x3 nor 0x7 emitted; next pushed 0x01 emits 1,0.
REQ-034 Push 16 bytes continuously (FRAME_NIBBLES=16) -> frame_done pulses on nibble 16 and 32, counter wraps, underrun stays 0.

Source files
------------

// File: rtl/s4ga_feeder.sv
// s4ga_feeder: byte FIFO feeding a nibble serializer for s4ga configuration.
// Each byte leaves as two nibbles, low nibble first, at up to one nibble per clock.
// Frames of FRAME_NIBBLES nibbles are marked by a frame_done pulse.
// Optional feature: define S4GA_FEEDER_UNDERRUN_EN to enable sticky detection
// of mid-frame starvation on the underrun output. Otherwise underrun is tied low.
module s4ga_feeder #(
    parameter int DEPTH         = 4,
    parameter int FRAME_NIBBLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] si,
    output logic       si_valid,
    output logic       frame_done,
    output logic       underrun
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CTW = AW + 1;
    localparam int CW  = $clog2(FRAME_NIBBLES);
    localparam logic [CW-1:0]  LAST_NIB = CW'(FRAME_NIBBLES - 1);
    localparam logic [CTW-1:0] FULL_CNT = CTW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    // FIFO storage. The read is asynchronous so that a byte written at one
    // edge can be popped at the very next edge, which the nibble latency needs.
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CTW-1:0] count_reg;
    logic           push;
    logic           pop;
    logic           fifo_empty;
    logic [7:0]     head;

    // Serializer state and registered outputs.
    state_t         state_reg;
    state_t         state_next;
    logic [3:0]     hi_nib_reg;
    logic [3:0]     hi_nib_next;
    logic [3:0]     si_reg;
    logic [3:0]     si_next;
    logic           si_valid_reg;
    logic           si_valid_next;
    logic           frame_done_reg;
    logic           frame_done_next;
    logic [CW-1:0]  cnt_reg;
    logic [CW-1:0]  cnt_next;

    // in_ready depends only on stored occupancy, so a full FIFO never
    // accepts a byte even on a cycle where it is also being popped.
    assign in_ready   = (count_reg < FULL_CNT);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count_reg == '0);
    assign head       = mem[rd_ptr_reg];

    assign si         = si_reg;
    assign si_valid   = si_valid_reg;
    assign frame_done = frame_done_reg;

    // Write the accepted byte into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CTW'(1);
                2'b01:   count_reg <= count_reg - CTW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Next-state, pop decision and next values of the registered outputs.
    always_comb begin
        state_next      = state_reg;
        hi_nib_next     = hi_nib_reg;
        pop             = 1'b0;
        si_next         = 4'd0;
        si_valid_next   = 1'b0;
        case (state_reg)
            IDLE, HI: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    hi_nib_next   = head[7:4];
                    si_next       = head[3:0];
                    si_valid_next = 1'b1;
                    state_next    = LO;
                end else begin
                    state_next    = IDLE;
                end
            end
            LO: begin
                si_next       = hi_nib_reg;
                si_valid_next = 1'b1;
                state_next    = HI;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The counter holds the index of the next nibble to be presented.
        frame_done_next = si_valid_next && (cnt_reg == LAST_NIB);
        cnt_next        = cnt_reg;
        if (si_valid_next) begin
            cnt_next = (cnt_reg == LAST_NIB) ? '0 : cnt_reg + CW'(1);
        end
    end

    // Register serializer state, counter and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            hi_nib_reg     <= 4'd0;
            si_reg         <= 4'd0;
            si_valid_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            hi_nib_reg     <= hi_nib_next;
            si_reg         <= si_next;
            si_valid_reg   <= si_valid_next;
            frame_done_reg <= frame_done_next;
            cnt_reg        <= cnt_next;
        end
    end

`ifdef S4GA_FEEDER_UNDERRUN_EN
    logic underrun_reg;

    // Sticky flag: the serializer went idle after a high nibble while the
    // frame was still incomplete (counter not back at zero).
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_reg <= 1'b0;
        end else if ((state_reg == HI) && fifo_empty && (cnt_reg != '0)) begin
            underrun_reg <= 1'b1;
        end
    end

    assign underrun = underrun_reg;
`else
    assign underrun = 1'b0;
`endif

endmodule
